// File: rtl/axis_pipe_adapter.sv
// Valid/ready wrapper around an enable-stalled fixed-latency pipeline.
// Credits from registered occupancy drive the pipeline enable; the pipeline output lands in a small FIFO.
module axis_pipe_adapter #(
   parameter int W       = 8,
   parameter int LATENCY = 4,
   parameter int DEPTH   = LATENCY + 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [W-1:0]               s_data,
   output logic                       pipe_e,
   output logic [W-1:0]               pipe_i,
   input  logic [W-1:0]               pipe_o,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [W-1:0]               m_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Handshake: a word moves on any rising edge where valid && ready; ready never
   // depends on valid, and s_ready is driven only from registered occupancy.
   logic [LATENCY-1:0] vld;
   logic [CW-1:0]      inflight;
   logic [CW-1:0]      fifo_cnt;
   logic [CW-1:0]      count_q;
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [W-1:0]       mem [DEPTH];
   logic               accept;
   logic               capture;
   logic               pop;

   assign pipe_e  = !rst && (count_q < CW'(DEPTH));
   assign s_ready = pipe_e;
   assign pipe_i  = s_data;
   assign accept  = s_valid && pipe_e;
   assign capture = pipe_e && vld[LATENCY-1];
   assign m_valid = (fifo_cnt != '0);
   assign pop     = m_valid && m_ready;
   assign m_data  = mem[rd_ptr];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld      <= '0;
         inflight <= '0;
         fifo_cnt <= '0;
         count_q  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         // vld mirrors the pipeline's data registers, so it shifts only when they do.
         if (pipe_e) begin
            vld[0] <= s_valid;
            for (int k = 1; k < LATENCY; k++) begin
               vld[k] <= vld[k-1];
            end
         end
         inflight <= inflight + CW'(accept) - CW'(capture);
         fifo_cnt <= fifo_cnt + CW'(capture) - CW'(pop);
         count_q  <= count_q + CW'(accept) - CW'(pop);
         if (capture) begin
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
      end
   end

   // Storage needs no reset; entries are only read once fifo_cnt says they hold data.
   always_ff @(posedge clk) begin
      if (capture) begin
         mem[wr_ptr] <= pipe_o;
      end
   end

endmodule

// File: tb/tb_axis_pipe_adapter.sv
// Bench for axis_pipe_adapter with an enable-stalled delay-line model attached to pipe_e/pipe_i/pipe_o.
// Accepted words go into exp_q; a monitor pops and compares every downstream transfer.
module tb_axis_pipe_adapter;

   localparam int W       = 8;
   localparam int LATENCY = 4;
   localparam int DEPTH   = 6;
   localparam int CW      = $clog2(DEPTH + 1);

   logic          clk;
   logic          rst;
   logic          s_valid;
   logic          s_ready;
   logic [W-1:0]  s_data;
   logic          pipe_e;
   logic [W-1:0]  pipe_i;
   logic [W-1:0]  pipe_o;
   logic          m_valid;
   logic          m_ready;
   logic [W-1:0]  m_data;
   logic [CW-1:0] count;

   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  stg [LATENCY];
   int            checks = 0;
   int            errors = 0;
   int            rx_cnt = 0;

   axis_pipe_adapter #(.W(W), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .pipe_e  (pipe_e),
      .pipe_i  (pipe_i),
      .pipe_o  (pipe_o),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .count   (count)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Wrapped delay line: data advances only on enabled edges and is never reset.
   always @(posedge clk) begin
      if (pipe_e) begin
         stg[0] <= pipe_i;
         for (int k = 1; k < LATENCY; k++) stg[k] <= stg[k-1];
      end
   end
   assign pipe_o = stg[LATENCY-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Scoreboard: push on upstream transfer, pop and compare on downstream transfer.
   always @(negedge clk) begin
      if (!rst) begin
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: got %0h expected nothing at %0t", m_data, $time);
            end else begin
               chk("m_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
               rx_cnt++;
            end
         end
         if (s_valid && s_ready) exp_q.push_back(s_data);
      end
   end

   // Invariants checked every cycle.
   always @(negedge clk) begin
      chk("s_ready_eq_pipe_e", {31'd0, s_ready}, {31'd0, pipe_e});
      chk("count_le_depth", {31'd0, (count <= CW'(DEPTH))}, 32'd1);
      if (!rst && pipe_e && dut.vld[LATENCY-1])
         chk("no_write_when_full", {31'd0, (dut.fifo_cnt == CW'(DEPTH))}, 32'd0);
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Driver tasks
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      bit done = 1'b0;
      m_ready = 1'b1;
      s_valid = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && count == '0) done = 1'b1;
      end
      chk("drain", {31'd0, done}, 32'd1);
   endtask

   int nacc;
   int sent;

   initial begin
      rst = 1'b1; s_valid = 1'b1; s_data = 8'h77; m_ready = 1'b1;

      // 1: reset hold
      repeat (3) begin
         next_cycle();
         @(negedge clk);
         chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
         chk("rst_pipe_e",  {31'd0, pipe_e},  32'd0);
         chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
         chk("rst_count",   {29'd0, count},   32'd0);
      end
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
      next_cycle();
      s_valid = 1'b0;
      drain();

      // 2: single word latency
      next_cycle();
      s_valid = 1'b1; s_data = 8'hA5;
      @(negedge clk);
      chk("single_accept", {31'd0, s_ready}, 32'd1);
      for (int c = 1; c <= 6; c++) begin
         next_cycle();
         s_valid = 1'b0;
         @(negedge clk);
         chk("single_m_valid", {31'd0, m_valid}, {31'd0, (c == 5)});
         chk("single_count", {29'd0, count}, (c <= 5) ? 32'd1 : 32'd0);
         if (c == 5) chk("single_m_data", {24'd0, m_data}, 32'hA5);
      end
      drain();

      // 3: full throughput stream
      for (int i = 0; i < 26; i++) begin
         next_cycle();
         s_valid = (i < 20);
         s_data  = W'(i);
         @(negedge clk);
         if (i < 20) chk("stream_s_ready", {31'd0, s_ready}, 32'd1);
         chk("stream_m_valid", {31'd0, m_valid}, {31'd0, (i >= 5 && i < 25)});
      end
      drain();

      // 4: backpressure
      m_ready = 1'b0;
      nacc = 0;
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         s_valid = 1'b1;
         s_data  = 8'h40 + W'(nacc);
         @(negedge clk);
         if (s_valid && s_ready) nacc++;
      end
      chk("bp_accepts", nacc, 32'd6);
      chk("bp_s_ready", {31'd0, s_ready}, 32'd0);
      chk("bp_count",   {29'd0, count},   32'd6);
      chk("bp_m_valid", {31'd0, m_valid}, 32'd1);
      chk("bp_m_data",  {24'd0, m_data},  32'h40);
      next_cycle();
      s_valid = 1'b0; m_ready = 1'b1;
      @(negedge clk);
      chk("bp_pop_cycle_s_ready", {31'd0, s_ready}, 32'd0);
      next_cycle();
      @(negedge clk);
      chk("bp_reopen_s_ready", {31'd0, s_ready}, 32'd1);
      drain();

      // 5: random valid/ready
      sent = 0;
      for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
         next_cycle();
         if (!s_valid || s_ready) s_data = W'($urandom_range(0, 255));
         s_valid = ($urandom_range(0, 1) == 1);
         m_ready = ($urandom_range(0, 1) == 1);
         @(negedge clk);
         if (s_valid && s_ready) sent++;
      end
      chk("random_sent", sent, 32'd1000);
      next_cycle();
      drain();

      // 6: reset with words queued and in flight
      m_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         next_cycle();
         s_valid = (i < 3 || i >= 7);
         s_data  = 8'hE0 + W'(i);
         @(negedge clk);
      end
      next_cycle();
      s_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_count",   {29'd0, count},   32'd5);
      chk("pre_rst_m_valid", {31'd0, m_valid}, 32'd1);
      next_cycle();
      rst = 1'b1;
      exp_q.delete();
      rx_cnt = 0;
      next_cycle();
      rst = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);
      chk("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
      chk("mid_rst_count",   {29'd0, count},   32'd0);
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         s_valid = 1'b1;
         s_data  = 8'h10 + W'(i);
         @(negedge clk);
         chk("post_rst_stream_s_ready", {31'd0, s_ready}, 32'd1);
      end
      next_cycle();
      drain();
      chk("post_rst_rx_cnt", rx_cnt, 32'd8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
